// File: rtl/vga_fb_scanout.sv
// vga_fb_scanout: VGA raster timing and double-buffered 1-bit framebuffer scanout,
// with a two-stage pipeline that keeps sync and colour aligned to the read data.
module vga_fb_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_SYNC_START = 656,
    parameter int H_SYNC_END = 751,
    parameter int H_TOTAL = 800,
    parameter int V_ACTIVE = 480,
    parameter int V_SYNC_START = 490,
    parameter int V_SYNC_END = 491,
    parameter int V_TOTAL = 525,
    parameter logic [11:0] FG_COLOR = 12'hFFF,
    parameter logic [11:0] BG_COLOR = 12'h000
) (
    input  logic        CLK_25,
    input  logic        RESET_N,
    output logic        rd_en,
    output logic [11:0] rd_x,
    output logic [11:0] rd_y,
    output logic        rd_buf,
    input  logic        rd_data,
    input  logic        swap_req,
    output logic        swap_ack,
    output logic        frame_start,
    output logic        in_vblank,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic [3:0]  VGA_R,
    output logic [3:0]  VGA_G,
    output logic [3:0]  VGA_B
);
    typedef enum logic {IDLE, ACK} state_t;
    state_t state;
    logic [11:0] h_count, v_count;
    logic active, act1, hs1, vs1, h_last, v_last;
    assign h_last = h_count == 12'(H_TOTAL - 1);
    assign v_last = v_count == 12'(V_TOTAL - 1);
    assign active = (h_count < 12'(H_ACTIVE)) && (v_count < 12'(V_ACTIVE));
    assign rd_en = active;
    assign rd_x = active ? h_count : '0;
    assign rd_y = active ? v_count : '0;
    assign in_vblank = v_count >= 12'(V_ACTIVE);
    always_ff @(posedge CLK_25) begin
        if (!RESET_N) begin
            h_count <= '0;
            v_count <= '0;
            act1 <= 1'b0;
            hs1 <= 1'b1;
            vs1 <= 1'b1;
            VGA_HS <= 1'b1;
            VGA_VS <= 1'b1;
            {VGA_R, VGA_G, VGA_B} <= 12'h000;
            frame_start <= 1'b0;
        end else begin
            h_count <= h_last ? '0 : h_count + 12'd1;
            if (h_last)
                v_count <= v_last ? '0 : v_count + 12'd1;
            act1 <= active;
            hs1 <= !(h_count >= 12'(H_SYNC_START) && h_count <= 12'(H_SYNC_END));
            vs1 <= !(v_count >= 12'(V_SYNC_START) && v_count <= 12'(V_SYNC_END));
            VGA_HS <= hs1;
            VGA_VS <= vs1;
            // rd_data answers the read issued one clock earlier, so it pairs with act1
            {VGA_R, VGA_G, VGA_B} <= act1 ? (rd_data ? FG_COLOR : BG_COLOR) : 12'h000;
            frame_start <= h_last && v_last;
        end
    end
    // Flip only on the last clock of the final visible line, so the new buffer starts in vblank
    always_ff @(posedge CLK_25) begin
        if (!RESET_N) begin
            state <= IDLE;
            rd_buf <= 1'b0;
            swap_ack <= 1'b0;
        end else if (state == IDLE) begin
            if (h_last && v_count == 12'(V_ACTIVE - 1) && swap_req) begin
                rd_buf <= ~rd_buf;
                swap_ack <= 1'b1;
                state <= ACK;
            end
        end else begin
            swap_ack <= 1'b0;
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_vga_fb_scanout.sv
// tb_vga_fb_scanout: scoreboard bench on a shrunken raster; the reference derives every
// output from the cycle index since reset and the framebuffer contents.
module tb_vga_fb_scanout;
    localparam int HA = 16, HSS = 18, HSE = 21, HT = 24;
    localparam int VA = 10, VSS = 11, VSE = 12, VT = 14;
    localparam int F = HT * VT;

    typedef struct {logic en; logic [11:0] x, y; logic vb, bf, ack, fs;} s0_t;
    typedef struct {logic hs, vs; logic [11:0] rgb;} px_t;

    logic CLK_25, RESET_N, rd_en, rd_buf, rd_data, swap_req, swap_ack, frame_start, in_vblank;
    logic VGA_HS, VGA_VS;
    logic [11:0] rd_x, rd_y;
    logic [3:0] VGA_R, VGA_G, VGA_B;

    bit fb[2][VA][HA];
    s0_t q0[$];
    px_t qv[$];
    int cmp_cnt = 0, mis_cnt = 0;
    int k = 0;
    bit mb = 0, pend = 0;

    vga_fb_scanout #(
        .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_END(HSE), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_END(VSE), .V_TOTAL(VT),
        .FG_COLOR(12'hFFF), .BG_COLOR(12'h000)
    ) dut (
        .CLK_25(CLK_25), .RESET_N(RESET_N), .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y),
        .rd_buf(rd_buf), .rd_data(rd_data), .swap_req(swap_req), .swap_ack(swap_ack),
        .frame_start(frame_start), .in_vblank(in_vblank), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
    );

    initial begin
        CLK_25 = 0;
        forever #5 CLK_25 = ~CLK_25;
    end

    function automatic px_t pixel(int kk, bit b);
        px_t p;
        int h = kk % HT, v = (kk / HT) % VT;
        p.hs = !(h >= HSS && h <= HSE);
        p.vs = !(v >= VSS && v <= VSE);
        p.rgb = (h < HA && v < VA) ? (fb[b][v % VA][h % HA] ? 12'hFFF : 12'h000) : 12'h000;
        return p;
    endfunction

    task automatic chk(string nm, logic [11:0] act, logic [11:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            mis_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Synchronous framebuffer: answers one clock later; drives 1 outside the active area
    initial forever begin
        @(negedge CLK_25);
        pend = (rd_en === 1'b1 && rd_x < 12'(HA) && rd_y < 12'(VA)) ? fb[rd_buf][rd_y][rd_x] : 1'b1;
        @(posedge CLK_25);
        #1 rd_data = pend;
    end

    // Reference model: inputs change at posedge+2, so values seen at posedge+1 are the sampled ones
    initial forever begin
        s0_t e;
        int h, v;
        px_t idle;
        @(posedge CLK_25);
        #1;
        idle.hs = 1; idle.vs = 1; idle.rgb = 12'h000;
        e.ack = 0;
        if (!RESET_N) begin
            k = 0;
            mb = 0;
            qv.delete();
            qv.push_back(idle);
            qv.push_back(idle);
        end else begin
            k++;
            if (k % F == VA * HT && swap_req) begin
                mb = ~mb;
                e.ack = 1;
            end
        end
        h = k % HT;
        v = (k / HT) % VT;
        e.en = h < HA && v < VA;
        e.x = e.en ? 12'(h) : 12'd0;
        e.y = e.en ? 12'(v) : 12'd0;
        e.vb = v >= VA;
        e.bf = mb;
        e.fs = k > 0 && k % F == 0;
        q0.push_back(e);
        qv.push_back(pixel(k, mb));
    end

    // Monitor: stage-0 outputs now, the pixel issued two clocks ago on the VGA pins
    initial forever begin
        s0_t e;
        px_t p;
        @(negedge CLK_25);
        if (q0.size() > 0) begin
            e = q0.pop_front();
            chk("rd_en", 12'(rd_en), 12'(e.en));
            chk("rd_x", rd_x, e.x);
            chk("rd_y", rd_y, e.y);
            chk("in_vblank", 12'(in_vblank), 12'(e.vb));
            chk("rd_buf", 12'(rd_buf), 12'(e.bf));
            chk("swap_ack", 12'(swap_ack), 12'(e.ack));
            chk("frame_start", 12'(frame_start), 12'(e.fs));
        end
        if (qv.size() > 2) begin
            p = qv.pop_front();
            chk("VGA_HS", 12'(VGA_HS), 12'(p.hs));
            chk("VGA_VS", 12'(VGA_VS), 12'(p.vs));
            chk("RGB", {VGA_R, VGA_G, VGA_B}, p.rgb);
        end
    end

    task automatic step(int n);
        repeat (n) begin
            @(posedge CLK_25);
            #2;
        end
    endtask

    initial begin
        int acks;
        RESET_N = 0;
        swap_req = 0;
        rd_data = 0;
        fb[0][5][10] = 1;
        fb[1][2][3] = 1;
        step(5);
        RESET_N = 1;
        step(2 * F);
        // request mid-line in the visible area, drop it right after the ack
        step(3 * HT + 7);
        swap_req = 1;
        for (int i = 0; i < 2 * F && swap_ack !== 1'b1; i++) step(1);
        step(1);
        swap_req = 0;
        step(2 * F);
        swap_req = 1;
        step(3 * F);
        swap_req = 0;
        RESET_N = 0;
        foreach (fb[b, y, x]) fb[b][y][x] = 1'($urandom);
        step(1);
        RESET_N = 1;
        for (int i = 0; i < 8 * F; i++) begin
            if ($urandom_range(0, 99) == 0) swap_req = ~swap_req;
            step(1);
        end
        // reset for one clock mid-frame with a pending request
        swap_req = 1;
        step(F - (k % F) + 5 * HT + 3);
        RESET_N = 0;
        step(1);
        RESET_N = 1;
        acks = 0;
        for (int i = 0; i < VA * HT - 1; i++) begin
            step(1);
            acks += int'(swap_ack === 1'b1);
        end
        cmp_cnt++;
        if (acks != 0) begin
            mis_cnt++;
            $display("FAIL early_ack_after_reset: got %0d acks expected 0", acks);
        end
        step(2 * F);
        swap_req = 0;
        step(F);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
        $finish;
    end
endmodule
